// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, one parity bit (even/odd selectable), one stop bit.
// Samples mid-bit from a 2-flop synchronised line and reports each frame with a one-cycle flag.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       Parity_sel,
  output logic [7:0] data,
  output logic       inFlag,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             psel_q, psel_d;
  logic             perr_pend_q, perr_pend_d;
  logic [7:0]       data_q, data_d;
  logic             inflag_q, inflag_d;
  logic             perr_q, perr_d;
  logic             ferr_q, ferr_d;
  logic             busy_q, busy_d;

  logic rx_meta_q, rx_s_q, rx_prev_q;
  logic bit_end;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      psel_q      <= 1'b0;
      perr_pend_q <= 1'b0;
      data_q      <= '0;
      inflag_q    <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      psel_q      <= psel_d;
      perr_pend_q <= perr_pend_d;
      data_q      <= data_d;
      inflag_q    <= inflag_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      busy_q      <= busy_d;
    end
  end

  assign bit_end = (cnt_q == BIT_LAST);

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    psel_d      = psel_q;
    perr_pend_d = perr_pend_q;
    data_d      = data_q;
    inflag_d    = 1'b0;
    perr_d      = perr_q;
    ferr_d      = ferr_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_s_q) begin
          state_d = START;
          psel_d  = Parity_sel;
        end
      end

      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DATA: begin
        if (bit_end) begin
          cnt_d     = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = PARITY;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      PARITY: begin
        if (bit_end) begin
          cnt_d       = '0;
          perr_pend_d = ((^shift_q) ^ rx_s_q) != psel_q;
          state_d     = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      STOP: begin
        if (bit_end) begin
          cnt_d    = '0;
          data_d   = shift_q;
          perr_d   = perr_pend_q;
          ferr_d   = !rx_s_q;
          inflag_d = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign data       = data_q;
  assign inFlag     = inflag_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized frames for uart_rx, checked against a frame-level reference model.
module tb_uart_rx;

  localparam int unsigned CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       Parity_sel;
  logic [7:0] data;
  logic       inFlag;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } rec_t;

  rec_t got_q[$];
  rec_t exp_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_flag_cyc = 0;
  int dbl_pulse = 0;
  logic prev_flag = 1'b0;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .Parity_sel (Parity_sel),
    .data       (data),
    .inFlag     (inFlag),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #10 clk = ~clk;

  // Capture every reported frame away from the active edge
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (inFlag) begin
      got_q.push_back('{d: data, pe: parity_err, fe: frame_err});
      last_flag_cyc = cyc;
      if (prev_flag) dbl_pulse = dbl_pulse + 1;
    end
    prev_flag = inFlag;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic rec_t model(input logic [7:0] d, input logic pbit, input logic sbit,
                                 input logic psel);
    rec_t r;
    int ones;
    ones = $countones(d) + int'(pbit);
    r.d  = d;
    r.pe = ((ones % 2) == 1) != psel;
    r.fe = (sbit == 1'b0);
    return r;
  endfunction

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  // Full frame; optionally flips Parity_sel partway through the data bits
  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic sbit,
                            input logic psel, input logic flip_mid);
    Parity_sel = psel;
    exp_q.push_back(model(d, pbit, sbit, psel));
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (flip_mid && i == 4) Parity_sel = ~psel;
      send_bit(d[i]);
    end
    send_bit(pbit);
    send_bit(sbit);
    rx = 1'b1;
  endtask

  task automatic compare_frames(input string tag);
    int n;
    rec_t g, e;
    n = 0;
    while (got_q.size() < exp_q.size() && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_q.size() > 0) begin
        g = got_q.pop_front();
        chk({tag, "_frame"}, 32'(g), 32'(e));
      end
    end
    got_q.delete();
  endtask

  initial begin
    logic [7:0] d;
    logic       ps, pb, sb, fl;
    int         start_cyc;

    rst = 1'b0;
    rx = 1'b1;
    Parity_sel = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data", data, 0);
    chk("rst_flags", {inFlag, parity_err, frame_err, busy}, 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_busy", busy, 0);

    // 0x55 with even parity, and latency from start edge to flag
    start_cyc = cyc;
    send_frame(8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("latency_ok", ((last_flag_cyc - start_cyc) >= 168) && ((last_flag_cyc - start_cyc) <= 174), 1);
    compare_frames("even_55");
    repeat (4) @(negedge clk);

    // Odd parity sequence, including a parity error
    send_frame(8'h55, 1'b1, 1'b1, 1'b1, 1'b0);
    send_frame(8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
    send_frame(8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    compare_frames("odd_seq");
    chk("hold_perr", parity_err, 1);

    // Stop bit low
    send_frame(8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    compare_frames("stop_err");
    chk("hold_ferr", frame_err, 1);

    // Short glitch on an idle line must be rejected
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (8) @(negedge clk);
    chk("glitch_busy", busy, 0);
    repeat (CPB * 12) @(negedge clk);
    chk("glitch_noflag", got_q.size(), 0);
    chk("glitch_hold", {data, frame_err}, {8'h80, 1'b1});

    // Back-to-back frames with no idle gap
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
    compare_frames("b2b");

    // Break: line held low for many bit times yields one framing error
    Parity_sel = 1'b1;
    exp_q.push_back(model(8'h00, 1'b0, 1'b0, 1'b1));
    rx = 1'b0;
    repeat (CPB * 25) @(negedge clk);
    chk("break_busy", busy, 0);
    rx = 1'b1;
    repeat (CPB * 2) @(negedge clk);
    compare_frames("break");
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
    compare_frames("after_break");

    // Reset after the 4th data bit
    send_frame(8'hC3, 1'b0, 1'b1, 1'b0, 1'b0);
    compare_frames("pre_rst");
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rst = 1'b0;
    #1;
    chk("midrst_data", data, 0);
    chk("midrst_flags", {inFlag, parity_err, frame_err, busy}, 0);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (CPB * 8) @(negedge clk);
    chk("midrst_noflag", got_q.size(), 0);
    chk("midrst_busy", busy, 0);
    send_frame(8'h0F, 1'b0, 1'b1, 1'b0, 1'b0);
    compare_frames("post_rst");

    // Randomized frames, with parity/stop errors and mid-frame Parity_sel changes
    for (int k = 0; k < 24; k++) begin
      d  = 8'($urandom);
      ps = 1'($urandom);
      pb = (($countones(d) % 2) == 1) ^ ps;
      if ($urandom_range(3) == 0) pb = ~pb;
      sb = ($urandom_range(6) != 0);
      fl = 1'($urandom);
      send_frame(d, pb, sb, ps, fl);
      if ($urandom_range(1) == 1) repeat ($urandom_range(20)) @(negedge clk);
    end
    repeat (CPB) @(negedge clk);
    compare_frames("random");

    chk("single_cycle_flag", dbl_pulse, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
